// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory line port between the I-cache and D-cache.
// One line transaction in flight at a time; requests are latched at grant and responses steered to the owner.
module cache_arbiter #(
  parameter int s_line  = 256,
  parameter int RR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic              i_resp,
  output logic [s_line-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic              d_resp,
  output logic [s_line-1:0] d_rdata,
  input  logic [s_line-1:0] line_o,
  input  logic              resp_o,
  output logic [s_line-1:0] line_i,
  output logic [31:0]       address_i,
  output logic              read_i,
  output logic              write_i
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_I, S_SERVE_D} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [s_line-1:0]   r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_pick_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  assign w_grant = (r_state == S_IDLE) && (w_i_req || w_d_req);
  // r_last_grant is 1 when D was granted last; under round-robin the other side wins a tie.
  assign w_pick_d = w_d_req && (!w_i_req || (RR_MODE == 0) || !r_last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_addr       <= w_pick_d ? d_address : i_address;
        r_write      <= w_pick_d & d_write;
        r_last_grant <= w_pick_d;
        if (w_pick_d && d_write) begin
          r_wdata <= d_wdata;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = w_pick_d ? S_SERVE_D : S_SERVE_I;
        end
      end
      S_SERVE_I: begin
        if (resp_o) begin
          i_resp       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_SERVE_D: begin
        if (resp_o) begin
          d_resp       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign read_i    = (r_state != S_IDLE) && !r_write;
  assign write_i   = (r_state != S_IDLE) && r_write;
  assign address_i = r_addr;
  assign line_i    = r_wdata;
  assign i_rdata   = line_o;
  assign d_rdata   = line_o;

endmodule
